// File: rtl/fetch_pkg.sv
// fetch_pkg: shared defaults and state type for the instruction fetch sequencer.
package fetch_pkg;
   localparam int FETCH_ADDR_W = 8;
   localparam int FETCH_INSTR_W = 24;
   localparam logic [FETCH_INSTR_W-1:0] FETCH_HALT_INSTR = 24'hFFFFFF;
   typedef enum logic [1:0] {IDLE, RUN, HALT} fetch_state_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: two-entry shift buffer; entry 0 is always the head.
module fetch_fifo #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         push,
   input  logic         pop,
   input  logic         flush,
   input  logic [W-1:0] din,
   output logic [1:0]   count,
   output logic [W-1:0] head
);
   logic [W-1:0] e0, e1;
   always_ff @(posedge clk)
      if (reset || flush) count <= '0;
      else count <= count + {1'b0, push & ~pop} - {1'b0, pop & ~push};
   always_ff @(posedge clk)
      if (reset) begin
         e0 <= '0;
         e1 <= '0;
      end else if (!flush) begin
         if (pop) e0 <= (push && count == 2'd1) ? din : e1;
         else if (push && count == 2'd0) e0 <= din;
         if (push && (pop ? count == 2'd2 : count == 2'd1)) e1 <= din;
      end
   // Stale entries are masked so an empty buffer presents zeros downstream.
   assign head = (count != 2'd0) ? e0 : '0;
endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: fetches from a combinational instruction memory into a 2-deep decode stream,
// with redirect, halt detection and a registered debug read port that has memory priority.
module fetch_sequencer
   import fetch_pkg::*;
#(
   parameter int ADDR_W = FETCH_ADDR_W,
   parameter int INSTR_W = FETCH_INSTR_W,
   parameter logic [INSTR_W-1:0] HALT_INSTR = FETCH_HALT_INSTR
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [ADDR_W-1:0]  start_pc,
   input  logic               redirect,
   input  logic [ADDR_W-1:0]  redirect_pc,
   output logic [ADDR_W-1:0]  imem_addr,
   input  logic [INSTR_W-1:0] imem_instr,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [INSTR_W-1:0] out_instr,
   output logic [ADDR_W-1:0]  out_pc,
   input  logic               dbg_req,
   input  logic [ADDR_W-1:0]  dbg_addr,
   output logic               dbg_ack,
   output logic [INSTR_W-1:0] dbg_data,
   output logic               halted
);
   fetch_state_t state, next_state;
   logic [ADDR_W-1:0] pc;
   logic [1:0] count;
   logic redir, push, pop;
   always_ff @(posedge clk)
      if (reset) state <= IDLE;
      else state <= next_state;
   always_comb
      next_state = (state == IDLE) ? (start ? RUN : IDLE)
                 : redir ? RUN
                 : (state == RUN) ? ((push && imem_instr == HALT_INSTR) ? HALT : RUN)
                 : (start ? RUN : HALT);
   // Redirect takes the cycle: no push, no pop; debug steals the memory port from fetch.
   always_comb begin
      halted = state == HALT;
      imem_addr = dbg_req ? dbg_addr : pc;
      redir = redirect && state != IDLE;
      pop = out_valid && out_ready && !redir;
      push = state == RUN && !dbg_req && !redir && (!count[1] || pop);
   end
   always_ff @(posedge clk)
      if (reset) pc <= '0;
      else pc <= redir ? redirect_pc
               : (start && state != RUN) ? start_pc
               : push ? pc + 1'b1
               : pc;
   always_ff @(posedge clk)
      if (reset) begin
         dbg_ack <= 1'b0;
         dbg_data <= '0;
      end else begin
         dbg_ack <= dbg_req;
         if (dbg_req) dbg_data <= imem_instr;
      end
   fetch_fifo #(.W(ADDR_W + INSTR_W)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .pop   (pop),
      .flush (redir),
      .din   ({pc, imem_instr}),
      .count (count),
      .head  ({out_pc, out_instr})
   );
   assign out_valid = count != 2'd0;
endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, instruction address width.
REQ-002 SHALL have parameter INSTR_W, default 24, instruction word width.
REQ-003 SHALL have parameter HALT_INSTR, default 24'hFFFFFF, instruction word that stops fetching.
REQ-004 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-005 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 SHALL have port start, input, 1, pulse that begins fetching at start_pc.
REQ-007 SHALL have port start_pc, input, ADDR_W, initial fetch address.
REQ-008 SHALL have port redirect, input, 1, branch/jump taken; flush and reload PC.
REQ-009 SHALL have port redirect_pc, input, ADDR_W, redirect target.
REQ-010 SHALL have port imem_addr, output, ADDR_W, address to combinational instruction memory.
REQ-011 SHALL have port imem_instr, input, INSTR_W, same-cycle read data for imem_addr.
REQ-012 SHALL have ports out_valid (output, 1), out_ready (input, 1), out_instr (output, INSTR_W), out_pc (output, ADDR_W): decode-side valid/ready stream.
REQ-013 SHALL have ports dbg_req (input, 1), dbg_addr (input, ADDR_W), dbg_ack (output, 1), dbg_data (output, INSTR_W): debug read port sharing the memory.
REQ-014 SHALL have port halted, output, 1, high while state is HALT.

Function
REQ-015 SHALL implement states IDLE, RUN, HALT; IDLE->RUN on start (pc<=start_pc); RUN->HALT when HALT_INSTR is pushed; HALT->RUN on start (pc<=start_pc) or redirect (pc<=redirect_pc).
REQ-016 SHALL drive imem_addr = dbg_addr when dbg_req is high, else pc; debug always wins the memory.
REQ-017 SHALL, in RUN with dbg_req low, no redirect and push allowed, push {pc, imem_instr} into a 2-entry FIFO and set pc<=pc+1, wrapping 8'hFF->8'h00.
REQ-018 SHALL allow a push when FIFO count<2, or when count==2 and a pop occurs in the same cycle; otherwise pc holds (stall).
REQ-019 SHALL pop when out_valid && out_ready; out_valid = FIFO non-empty; out_instr/out_pc = FIFO head; FIFO order preserved.
REQ-020 SHALL, on redirect in RUN or HALT, flush the FIFO, suppress that cycle's push and pop, load pc<=redirect_pc, and enter RUN; out_valid is 0 next cycle.
REQ-021 SHALL ignore redirect in IDLE and ignore start in RUN.
REQ-022 SHALL, for each cycle dbg_req is high, assert dbg_ack exactly one cycle later with dbg_data = memory word at that dbg_addr, registered; back-to-back requests give back-to-back acks.
REQ-023 SHALL give first-instruction latency of 1 cycle: start at edge N -> out_valid high after edge N+1 if no dbg_req.
REQ-024 SHALL, when redirect and start arrive together in HALT, give redirect priority.
REQ-025 SHALL, in HALT and IDLE, keep draining the FIFO through out_ready.

Reset
REQ-026 SHALL on reset: state IDLE, pc=0, FIFO empty, out_valid=0, out_instr=0, out_pc=0, dbg_ack=0, dbg_data=0, halted=0.
REQ-027 SHALL apply reset mid-operation identically, discarding FIFO contents and any pending dbg_ack.

Structure
REQ-028 SHALL place ADDR_W, INSTR_W defaults, HALT_INSTR and the state enum fetch_state_t in package fetch_pkg.
REQ-029 SHALL implement the 2-entry buffer as sub-module fetch_fifo (push, pop, flush, count, head outputs).

Verification
REQ-030 SHALL test: memory 00:111111, 01:222222, 02:FFFFFF; start, start_pc=00, out_ready=1 -> outputs (00,111111),(01,222222),(02,FFFFFF) on consecutive cycles, then halted=1, no further fetch.
REQ-031 SHALL test: out_ready=0 for 5 cycles after start at 00 -> FIFO holds 00,01; pc stalls at 02; releasing ready yields 00,01,02 in order with no gaps.
REQ-032 SHALL test: redirect to 8'h05 while FIFO holds 2 entries -> out_valid=0 next cycle, next output is (05, mem[05]).
REQ-033 SHALL test: dbg_req with dbg_addr=8'h03 during RUN -> dbg_ack one cycle later with dbg_data=mem[03]; fetch pc unchanged that cycle.
REQ-034 SHALL test: start_pc=8'hFE, memory without halt -> out_pc sequence FE, FF, 00, 01.
REQ-035 SHALL test: reset asserted with FIFO full and dbg_req pending -> next cycle all outputs 0, state IDLE.
